mips_cpu_writeback_queue: RTL and testbench

//  Drives the register-file write port (write_enable/write_reg/write_data); the block on the far side of that port.

---
 rtl/mips_cpu_writeback_queue.sv | 130 +++++++++++++
 tb/tb_mips_cpu_writeback_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_writeback_queue.sv
// rtl/mips_cpu_writeback_queue.sv - register-file write port merging primary results with a FIFO of secondary results
// Optional feature macro: WRITEBACK_BYPASS_EN (youngest-match forwarding data on fwd_data).
module mips_cpu_writeback_queue #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pri_valid,
  input  logic [4:0]  pri_reg,
  input  logic [31:0] pri_data,
  output logic        pri_stall,
  input  logic        sec_valid,
  output logic        sec_ready,
  input  logic [4:0]  sec_reg,
  input  logic [31:0] sec_data,
  input  logic [4:0]  query_reg,
  output logic        pending_hit,
  output logic [31:0] fwd_data,
  output logic        write_enable,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {ARB_IDLE, ARB_FORCE, ARB_PRI, ARB_POP} arb_t;

  logic [4:0]       q_reg  [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      count;
  logic [SW-1:0]    starve;

  arb_t        arb;
  logic        push, pop;
  logic        issue_en;
  logic [4:0]  issue_reg;
  logic [31:0] issue_data;

  // Arbitration: a starved FIFO beats the primary, which beats an ordinary pop.
  always_comb begin
    sec_ready  = reset && (count != (AW+1)'(DEPTH));
    push       = sec_valid && sec_ready && (sec_reg != 5'd0);
    arb        = ARB_IDLE;
    if (reset && (starve == SW'(STARVE_LIMIT)))
      arb = ARB_FORCE;
    else if (pri_valid && (pri_reg != 5'd0))
      arb = ARB_PRI;
    else if (count != '0)
      arb = ARB_POP;
    pop        = (arb == ARB_FORCE) || (arb == ARB_POP);
    pri_stall  = (arb == ARB_FORCE);
    issue_en   = 1'b0;
    issue_reg  = 5'd0;
    issue_data = 32'd0;
    if (arb == ARB_PRI) begin
      issue_en   = 1'b1;
      issue_reg  = pri_reg;
      issue_data = pri_data;
    end else if (pop && q_vld[rd_ptr]) begin
      issue_en   = 1'b1;
      issue_reg  = q_reg[rd_ptr];
      issue_data = q_data[rd_ptr];
    end
  end

  // Walk oldest to youngest so a younger match overrides an older one.
  always_comb begin
    logic [AW-1:0] idx;
    pending_hit = 1'b0;
    fwd_data    = 32'd0;
    idx         = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (q_vld[idx] && (q_reg[idx] == query_reg) && (query_reg != 5'd0)) begin
        pending_hit = 1'b1;
`ifdef WRITEBACK_BYPASS_EN
        fwd_data    = q_data[idx];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      starve       <= '0;
      q_vld        <= '0;
      write_enable <= 1'b0;
      write_reg    <= 5'd0;
      write_data   <= 32'd0;
    end else begin
      write_enable <= issue_en;
      write_reg    <= issue_reg;
      write_data   <= issue_data;
      // Killed entries keep their slot; they are skipped silently when popped.
      if (arb == ARB_PRI) begin
        for (int i = 0; i < DEPTH; i++)
          if (q_vld[i] && (q_reg[i] == pri_reg))
            q_vld[i] <= 1'b0;
      end
      if (pop) begin
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + AW'(1);
      end
      if (push) begin
        q_vld[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + AW'(1);
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (pop || (count == '0))
        starve <= '0;
      else if (starve != SW'(STARVE_LIMIT))
        starve <= starve + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_reg[wr_ptr]  <= sec_reg;
      q_data[wr_ptr] <= sec_data;
    end
  end

endmodule

// File: tb/tb_mips_cpu_writeback_queue.sv
// tb/tb_mips_cpu_writeback_queue.sv - randomized and directed bench against a queue-based reference model
module tb_mips_cpu_writeback_queue;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        pri_valid, pri_stall, sec_valid, sec_ready, pending_hit, write_enable;
  logic [4:0]  pri_reg, sec_reg, query_reg, write_reg;
  logic [31:0] pri_data, sec_data, fwd_data, write_data;

  mips_cpu_writeback_queue #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pri_valid(pri_valid), .pri_reg(pri_reg), .pri_data(pri_data), .pri_stall(pri_stall),
    .sec_valid(sec_valid), .sec_ready(sec_ready), .sec_reg(sec_reg), .sec_data(sec_data),
    .query_reg(query_reg), .pending_hit(pending_hit), .fwd_data(fwd_data),
    .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {logic [4:0] r; logic [31:0] d; bit v;} ent_t;
  ent_t        mq[$];
  int          mstarve = 0;
  bit          exp_we, exp_ready, exp_stall, exp_hit;
  logic [4:0]  exp_reg;
  logic [31:0] exp_data, exp_fwd;

  function automatic void model_comb();
    exp_ready = reset && (mq.size() != DEPTH);
    exp_stall = reset && (mstarve == LIMIT);
    exp_hit   = 1'b0;
    exp_fwd   = 32'd0;
    foreach (mq[i])
      if (mq[i].v && mq[i].r == query_reg && query_reg != 5'd0) begin
        exp_hit = 1'b1;
`ifdef WRITEBACK_BYPASS_EN
        exp_fwd = mq[i].d;
`endif
      end
  endfunction

  function automatic void model_update();
    bit   push;
    bit   popped;
    int   pre;
    ent_t h;
    exp_we = 1'b0; exp_reg = 5'd0; exp_data = 32'd0;
    if (!reset) begin
      mq.delete();
      mstarve = 0;
      return;
    end
    push   = sec_valid && (mq.size() != DEPTH) && (sec_reg != 5'd0);
    popped = 1'b0;
    pre    = mq.size();
    if (mstarve == LIMIT && pre != 0) begin
      h = mq.pop_front(); popped = 1'b1;
      if (h.v) begin exp_we = 1'b1; exp_reg = h.r; exp_data = h.d; end
    end else if (pri_valid && pri_reg != 5'd0) begin
      exp_we = 1'b1; exp_reg = pri_reg; exp_data = pri_data;
      foreach (mq[i]) if (mq[i].r == pri_reg) mq[i].v = 1'b0;
    end else if (pre != 0) begin
      h = mq.pop_front(); popped = 1'b1;
      if (h.v) begin exp_we = 1'b1; exp_reg = h.r; exp_data = h.d; end
    end
    mstarve = (pre != 0 && !popped) ? ((mstarve < LIMIT) ? mstarve + 1 : LIMIT) : 0;
    if (push) mq.push_back('{sec_reg, sec_data, 1'b1});
  endfunction

  task automatic drive_idle();
    pri_valid = 1'b0; pri_reg = 5'd0; pri_data = 32'd0;
    sec_valid = 1'b0; sec_reg = 5'd0; sec_data = 32'd0; query_reg = 5'd0;
  endtask

  task automatic eval();
    #1;
    model_comb();
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drain();
    drive_idle();
    for (int i = 0; i < DEPTH + 3; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pri_valid = 1'b1; pri_reg = 5'd3; pri_data = 32'd77;
    sec_valid = 1'b1; sec_reg = 5'd4; sec_data = 32'd5; query_reg = 5'd4;
    for (int i = 0; i < 3; i++) step();
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we actual=%0b required=0", write_enable); end
    checks++; if (write_reg !== 5'd0) begin errors++; $display("FAIL reset_reg actual=%0d required=0", write_reg); end
    checks++; if (write_data !== 32'd0) begin errors++; $display("FAIL reset_data actual=%0h required=0", write_data); end
    checks++; if (sec_ready !== 1'b0) begin errors++; $display("FAIL reset_sec_ready actual=%0b required=0", sec_ready); end
    checks++; if (pri_stall !== 1'b0) begin errors++; $display("FAIL reset_pri_stall actual=%0b required=0", pri_stall); end
    checks++; if (pending_hit !== 1'b0) begin errors++; $display("FAIL reset_pending actual=%0b required=0", pending_hit); end
    reset = 1'b1;
    drive_idle();
    eval();
    checks++; if (sec_ready !== 1'b1) begin errors++; $display("FAIL release_sec_ready actual=%0b required=1", sec_ready); end
    step();
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL release_empty_we actual=%0b required=0", write_enable); end
  endtask

  task automatic test_single_primary();
    pri_valid = 1'b1; pri_reg = 5'd16; pri_data = 32'd1234567;
    eval();
    checks++; if (pri_stall !== 1'b0) begin errors++; $display("FAIL single_stall actual=%0b required=0", pri_stall); end
    step();
    checks++; if ({write_enable, write_reg, write_data} !== {1'b1, 5'd16, 32'd1234567})
      begin errors++; $display("FAIL single_write actual=%0b/%0d/%0d required=1/16/1234567", write_enable, write_reg, write_data); end
    drive_idle();
    step();
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL single_after actual=%0b required=0", write_enable); end
  endtask

  task automatic test_fill_force();
    int waited;
    for (int k = 0; k < DEPTH; k++) begin
      pri_valid = 1'b1; pri_reg = 5'd30; pri_data = $urandom;
      sec_valid = 1'b1; sec_reg = 5'(k + 1); sec_data = 32'(1000 + k);
      eval();
      checks++; if (sec_ready !== 1'b1) begin errors++; $display("FAIL fill_ready k=%0d actual=%0b required=1", k, sec_ready); end
      step();
    end
    sec_valid = 1'b0;
    eval();
    checks++; if (sec_ready !== 1'b0) begin errors++; $display("FAIL full_ready actual=%0b required=0", sec_ready); end
    waited = -1;
    for (int c = 0; c < 20; c++) begin
      pri_data = $urandom;
      eval();
      checks++; if (pri_stall !== exp_stall) begin errors++; $display("FAIL starve_stall c=%0d actual=%0b required=%0b", c, pri_stall, exp_stall); end
      if (pri_stall === 1'b1) begin waited = c; break; end
      step();
    end
    checks++; if (waited != 5) begin errors++; $display("FAIL force_delay actual=%0d required=5", waited); end
    step();
    checks++; if ({write_enable, write_reg, write_data} !== {1'b1, 5'd1, 32'd1000})
      begin errors++; $display("FAIL force_write actual=%0b/%0d/%0d required=1/1/1000", write_enable, write_reg, write_data); end
    drain();
  endtask

  task automatic test_kill();
    pri_valid = 1'b1; pri_reg = 5'd9; pri_data = 32'd11;
    sec_valid = 1'b1; sec_reg = 5'd20; sec_data = 32'd7654321; query_reg = 5'd20;
    step();
    sec_valid = 1'b0;
    eval();
    checks++; if (pending_hit !== 1'b1) begin errors++; $display("FAIL kill_queued_hit actual=%0b required=1", pending_hit); end
    pri_reg = 5'd20; pri_data = 32'd5;
    step();
    checks++; if ({write_enable, write_reg, write_data} !== {1'b1, 5'd20, 32'd5})
      begin errors++; $display("FAIL kill_pri_write actual=%0b/%0d/%0d required=1/20/5", write_enable, write_reg, write_data); end
    pri_valid = 1'b0;
    eval();
    checks++; if (pending_hit !== 1'b0) begin errors++; $display("FAIL kill_hit_cleared actual=%0b required=0", pending_hit); end
    step();
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL kill_silent_pop actual=%0b required=0", write_enable); end
    step();
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL kill_empty actual=%0b required=0", write_enable); end
    drain();
  endtask

  task automatic test_reg0();
    pri_valid = 1'b1; pri_reg = 5'd9; pri_data = 32'd3;
    sec_valid = 1'b1; sec_reg = 5'd5; sec_data = 32'd9;
    step();
    sec_valid = 1'b0; pri_reg = 5'd0; pri_data = 32'hdead;
    eval();
    checks++; if (pri_stall !== 1'b0) begin errors++; $display("FAIL reg0_stall actual=%0b required=0", pri_stall); end
    step();
    checks++; if ({write_enable, write_reg, write_data} !== {1'b1, 5'd5, 32'd9})
      begin errors++; $display("FAIL reg0_pop actual=%0b/%0d/%0d required=1/5/9", write_enable, write_reg, write_data); end
    pri_reg = 5'd9;
    sec_valid = 1'b1; sec_reg = 5'd0; sec_data = 32'd99; query_reg = 5'd0;
    eval();
    checks++; if (sec_ready !== 1'b1) begin errors++; $display("FAIL reg0_sec_ready actual=%0b required=1", sec_ready); end
    step();
    checks++; if (pending_hit !== 1'b0) begin errors++; $display("FAIL reg0_hit actual=%0b required=0", pending_hit); end
    drive_idle();
    step();
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reg0_not_stored actual=%0b required=0", write_enable); end
  endtask

  task automatic test_bypass();
    logic [31:0] want_fwd;
`ifdef WRITEBACK_BYPASS_EN
    want_fwd = 32'd2;
`else
    want_fwd = 32'd0;
`endif
    pri_valid = 1'b1; pri_reg = 5'd9; pri_data = 32'd4;
    sec_valid = 1'b1; sec_reg = 5'd8; sec_data = 32'd1;
    step();
    sec_data = 32'd2;
    step();
    sec_valid = 1'b0; query_reg = 5'd8;
    eval();
    checks++; if (pending_hit !== 1'b1) begin errors++; $display("FAIL bypass_hit actual=%0b required=1", pending_hit); end
    checks++; if (fwd_data !== want_fwd) begin errors++; $display("FAIL bypass_fwd actual=%0d required=%0d", fwd_data, want_fwd); end
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      reset     = ($urandom_range(0, 63) != 0);
      pri_valid = ($urandom_range(0, 1) == 1);
      pri_reg   = 5'($urandom_range(0, 7));
      pri_data  = $urandom;
      sec_valid = ($urandom_range(0, 9) < 6);
      sec_reg   = 5'($urandom_range(0, 7));
      sec_data  = $urandom;
      query_reg = 5'($urandom_range(0, 7));
      eval();
      checks++; if (sec_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready n=%0d actual=%0b required=%0b", n, sec_ready, exp_ready); end
      checks++; if (pri_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall n=%0d actual=%0b required=%0b", n, pri_stall, exp_stall); end
      checks++; if (pending_hit !== exp_hit) begin errors++; $display("FAIL rnd_hit n=%0d actual=%0b required=%0b", n, pending_hit, exp_hit); end
      checks++; if (fwd_data !== exp_fwd) begin errors++; $display("FAIL rnd_fwd n=%0d actual=%0h required=%0h", n, fwd_data, exp_fwd); end
      step();
      checks++; if (write_enable !== exp_we) begin errors++; $display("FAIL rnd_we n=%0d actual=%0b required=%0b", n, write_enable, exp_we); end
      if (exp_we) begin
        checks++; if ({write_reg, write_data} !== {exp_reg, exp_data})
          begin errors++; $display("FAIL rnd_write n=%0d actual=%0d/%0h required=%0d/%0h", n, write_reg, write_data, exp_reg, exp_data); end
      end
    end
    reset = 1'b1;
    drain();
  endtask

  initial begin
    drive_idle();
    reset = 1'b0;
    test_reset();
    test_single_primary();
    test_fill_force();
    test_kill();
    test_reg0();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
